flit_pipe_buf: RTL



---
 rtl/flit_pipe_buf.sv | 116 +++++++++++
 1 files changed

// File: rtl/flit_pipe_buf.sv
// flit_pipe_buf: NCH-lane, DEPTH-stage flit pipeline with per-entry valid, global stall/flush and occupancy count.
// Optional macro FLIT_PIPE_BUF_PARITY_EN adds per-entry even parity with injection (par_inj) and checking (par_err).
module flit_pipe_buf #(
  parameter int NCH   = 5,
  parameter int DW    = 32,
  parameter int DEPTH = 2,
  localparam int CW   = $clog2(NCH*DEPTH+1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic [NCH-1:0]    in_valid,
  input  logic [NCH*DW-1:0] in_data,
`ifdef FLIT_PIPE_BUF_PARITY_EN
  input  logic [NCH-1:0]    par_inj,
  output logic [NCH-1:0]    par_err,
`endif
  output logic [NCH-1:0]    out_valid,
  output logic [NCH*DW-1:0] out_data,
  output logic              busy,
  output logic [CW-1:0]     count
);

  // Valid-only interface, no ready: a flit on lane c is accepted on any edge with
  // in_valid[c]=1, stall=0 and flush=0; otherwise it is dropped.
  logic [NCH-1:0]    vld_q [DEPTH];
  logic [NCH-1:0]    vld_d [DEPTH];
  logic [NCH*DW-1:0] dat_q [DEPTH];
  logic [NCH*DW-1:0] dat_d [DEPTH];
`ifdef FLIT_PIPE_BUF_PARITY_EN
  logic [NCH-1:0]    par_q [DEPTH];
  logic [NCH-1:0]    par_d [DEPTH];
  logic [NCH-1:0]    cap_par;

  always_comb begin
    cap_par = '0;
    for (int c = 0; c < NCH; c++) begin
      cap_par[c] = (^in_data[c*DW +: DW]) ^ par_inj[c];
    end
  end
`endif

  // Data/parity move with the pipe regardless of valid; flush only touches valids.
  always_comb begin
    for (int s = 0; s < DEPTH; s++) begin
      vld_d[s] = vld_q[s];
      dat_d[s] = dat_q[s];
`ifdef FLIT_PIPE_BUF_PARITY_EN
      par_d[s] = par_q[s];
`endif
    end
    if (flush) begin
      for (int s = 0; s < DEPTH; s++) begin
        vld_d[s] = '0;
      end
    end else if (!stall) begin
      vld_d[0] = in_valid;
      dat_d[0] = in_data;
`ifdef FLIT_PIPE_BUF_PARITY_EN
      par_d[0] = cap_par;
`endif
      for (int s = 1; s < DEPTH; s++) begin
        vld_d[s] = vld_q[s-1];
        dat_d[s] = dat_q[s-1];
`ifdef FLIT_PIPE_BUF_PARITY_EN
        par_d[s] = par_q[s-1];
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < DEPTH; s++) begin
        vld_q[s] <= '0;
        dat_q[s] <= '0;
`ifdef FLIT_PIPE_BUF_PARITY_EN
        par_q[s] <= '0;
`endif
      end
    end else begin
      for (int s = 0; s < DEPTH; s++) begin
        vld_q[s] <= vld_d[s];
        dat_q[s] <= dat_d[s];
`ifdef FLIT_PIPE_BUF_PARITY_EN
        par_q[s] <= par_d[s];
`endif
      end
    end
  end

  // Occupancy is a popcount of registered valids, so it tracks state with no lag.
  always_comb begin
    count = '0;
    for (int s = 0; s < DEPTH; s++) begin
      for (int c = 0; c < NCH; c++) begin
        count = count + CW'(vld_q[s][c]);
      end
    end
  end

  assign busy      = (count != '0);
  assign out_valid = vld_q[DEPTH-1];
  assign out_data  = dat_q[DEPTH-1];

`ifdef FLIT_PIPE_BUF_PARITY_EN
  always_comb begin
    par_err = '0;
    for (int c = 0; c < NCH; c++) begin
      par_err[c] = out_valid[c] & (par_q[DEPTH-1][c] != ^out_data[c*DW +: DW]);
    end
  end
`endif

endmodule
